mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
- Parametrised successor MEM pipeline stage, between EX and WB.
- Aligns and extends load data for XLEN 32 or 64.
- Holds a load response in a skid register when WB back-pressures, so no response is lost.
- Tracks loads flushed while in flight and discards their late data responses.
- Carries an opaque sideband bundle (CSR/trap fields) to WB unchanged.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- SB_W, 64, width of the pass-through sideband bundle.
- MAX_OUTSTANDING, 4, maximum number of discarded-response credits tracked.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mem_pipe_valid  in  1  EX->MEM entry valid
- mem_pipe_ready  out  1  MEM accepts entry
- mem_pipe_flush  out  1  flush toward EX, equals wb_pipe_flush
- mem_pipe_pc  in  XLEN  instruction PC
- mem_pipe_mem_read  in  1  entry is a load
- mem_pipe_mem_size  in  2  0=B, 1=H, 2=W, 3=D (D legal only when XLEN=64)
- mem_pipe_unsign  in  1  zero-extend load
- mem_pipe_rd_write  in  1  writes rd
- mem_pipe_rd_addr  in  5  rd index
- mem_pipe_alu_result  in  XLEN  ALU result or load address
- mem_pipe_sideband  in  SB_W  pass-through bundle
- mem_pipe_exc_pending  in  1  upstream exception pending
- mem_pipe_exc_code  in  4  exception code
- mem_pipe_exc_tval  in  XLEN  exception tval
- wb_pipe_ready  in  1  WB accepts
- wb_pipe_flush  in  1  flush from WB
- wb_pipe_valid  out  1  MEM->WB valid
- wb_pipe_pc, wb_pipe_rd_write, wb_pipe_rd_addr, wb_pipe_rd_data, wb_pipe_sideband, wb_pipe_exc_pending, wb_pipe_exc_code, wb_pipe_exc_tval  out  as inputs  registered copies
- mem_rd_write  out  1  forward: rd write pending (valid-qualified)
- mem_rd_addr  out  5  forward rd index
- mem_rd_wdata  out  XLEN  forward data
- mem_mem_read_wait  out  1  load in MEM without usable data yet
- mem_lsu_stall  out  1  discard counter full; EX must not issue a load
- dram_rvalid  in  1  load response valid, in request order
- dram_rdata  in  XLEN  load response data

Behaviour:
Interface:
- One clock, clk. Reset rst is synchronous and active-high.
- Reset clears wb_pipe_valid, the FSM (to IDLE), the hold register valid bit and discard_cnt.
- At reset the wb_pipe_* data registers hold their value; all other outputs are combinational.
- Responses arrive strictly in request order.

Response routing:
- A response with discard_cnt > 0 is dropped and discard_cnt decrements.
- Otherwise the response belongs to the load currently in MEM.

FSM (load entries only; non-load entries bypass it and complete in the same cycle):
- IDLE -> WAIT on a valid load with no owned data.
- WAIT + owned rvalid + wb_pipe_ready: forward to WB, return to IDLE.
- WAIT + owned rvalid + !wb_pipe_ready: latch aligned data into the hold register, go to HOLD.
- HOLD: present the held data; on wb_pipe_ready, transfer and return to IDLE.
- Data from the same cycle as rvalid and data from the hold register are used interchangeably.

Pipeline control:
- mem_valid = mem_pipe_valid & ~wb_pipe_flush.
- done = non-load | owned rvalid | HOLD.
- mem_pipe_ready = ~mem_valid | (done & wb_pipe_ready).
- When wb_pipe_ready=1, wb_pipe_valid <= done & mem_valid.
- Latency: non-load = 1 cycle; load = 1 cycle after rvalid.

Flush:
- wb_pipe_flush while in WAIT: discard_cnt++, FSM -> IDLE.
- wb_pipe_flush with a same-cycle owned rvalid: the response is consumed and dropped; count unchanged.
- wb_pipe_flush in HOLD: hold register cleared, FSM -> IDLE.
- discard_cnt saturates at MAX_OUTSTANDING.
- mem_lsu_stall = (discard_cnt == MAX_OUTSTANDING).

Alignment:
- Byte offset = alu_result[log2(XLEN/8)-1:0].
- B/H/W lanes are selected by the offset; sign- or zero-extended per unsign.
- W with unsign=1 is LWU, zero-extended to XLEN (meaningful when XLEN=64).
- D = full word.
- rd_data = load ? aligned data : alu_result.

Forwarding:
- mem_rd_write = mem_pipe_rd_write & mem_pipe_valid.
- mem_mem_read_wait = load & mem_pipe_valid & ~done.

Exceptions:
- exc_* and sideband are copied to WB with the entry, unchanged, except as described under the optional feature.

Optional Feature:
MEM_MISALIGN_EXC_EN
- Defined:
  - A load with H at odd offset, W with offset[1:0]!=0, or D with offset[2:0]!=0 completes immediately (no wait).
  - It sets wb_pipe_exc_pending=1, exc_code=4, exc_tval=alu_result, and rd_write=0.
  - Its still-pending response is dropped via discard_cnt++.
  - An upstream exc_pending takes priority over the misalign exception.
- Undefined: no misalign check; data is taken from the selected lanes as-is.

Test Plan:
- XLEN=32, LB at addr 0x103, rdata 0x80FF1234, wb_ready=1 -> rd_data 0xFFFFFF80, wb_pipe_valid exactly 1 cycle after rvalid.
- LHU at addr 0x2, rdata 0xBEEF0000, wb_ready=0 on the rvalid cycle, 1 two cycles later -> FSM HOLD, rd_data 0x0000BEEF delivered once, no loss.
- Load flushed in WAIT, next load issued, two rvalids (0x11, 0x22) -> first dropped, second delivered as 0x22, discard_cnt back to 0.
- Four flushed in-flight loads with MAX_OUTSTANDING=4 -> mem_lsu_stall=1 until first stale rvalid, then 0.
- XLEN=64, LWU at offset 4, rdata 0xFFFFFFFF_00000000 -> rd_data 0x00000000_FFFFFFFF.
- MEM_MISALIGN_EXC_EN defined, LW at addr 0x1002 -> exc_pending=1, code 4, tval 0x1002, rd_write=0, later rvalid dropped.

Source files
------------

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mem_stage_lsu: MEM stage with load alignment, WB skid hold and         |
// | stale-response discard tracking. Optional: MEM_MISALIGN_EXC_EN.        |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module mem_stage_lsu #(
    parameter int XLEN            = 32,
    parameter int SB_W            = 64,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_pipe_valid,
    output logic            mem_pipe_ready,
    output logic            mem_pipe_flush,
    input  logic [XLEN-1:0] mem_pipe_pc,
    input  logic            mem_pipe_mem_read,
    input  logic [1:0]      mem_pipe_mem_size,
    input  logic            mem_pipe_unsign,
    input  logic            mem_pipe_rd_write,
    input  logic [4:0]      mem_pipe_rd_addr,
    input  logic [XLEN-1:0] mem_pipe_alu_result,
    input  logic [SB_W-1:0] mem_pipe_sideband,
    input  logic            mem_pipe_exc_pending,
    input  logic [3:0]      mem_pipe_exc_code,
    input  logic [XLEN-1:0] mem_pipe_exc_tval,
    input  logic            wb_pipe_ready,
    input  logic            wb_pipe_flush,
    output logic            wb_pipe_valid,
    output logic [XLEN-1:0] wb_pipe_pc,
    output logic            wb_pipe_rd_write,
    output logic [4:0]      wb_pipe_rd_addr,
    output logic [XLEN-1:0] wb_pipe_rd_data,
    output logic [SB_W-1:0] wb_pipe_sideband,
    output logic            wb_pipe_exc_pending,
    output logic [3:0]      wb_pipe_exc_code,
    output logic [XLEN-1:0] wb_pipe_exc_tval,
    output logic            mem_rd_write,
    output logic [4:0]      mem_rd_addr,
    output logic [XLEN-1:0] mem_rd_wdata,
    output logic            mem_mem_read_wait,
    output logic            mem_lsu_stall,
    input  logic            dram_rvalid,
    input  logic [XLEN-1:0] dram_rdata
);

    localparam int                 c_OFF_W   = $clog2(XLEN / 8);
    localparam int                 c_CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(MAX_OUTSTANDING);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_HOLD = 2'd2;

    logic [1:0]         r_state;
    logic               r_hold_valid;
    logic [XLEN-1:0]    r_hold_data;
    logic [c_CNT_W-1:0] r_discard_cnt;
    logic [c_CNT_W-1:0] w_cnt_next;

    logic               w_load;
    logic               w_mem_valid;
    logic               w_in_hold;
    logic               w_owned;
    logic               w_misal;
    logic               w_misal_exc;
    logic               w_done;
    logic               w_xfer;
    logic               w_inc;
    logic               w_dec;
    logic [c_OFF_W-1:0] w_offset;
    logic [XLEN-1:0]    w_shifted;
    logic [XLEN-1:0]    w_aligned;
    logic [XLEN-1:0]    w_load_data;
    logic [XLEN-1:0]    w_rd_data;

    assign w_load      = mem_pipe_valid & mem_pipe_mem_read;
    assign w_mem_valid = mem_pipe_valid & ~wb_pipe_flush;
    assign w_in_hold   = (r_state == c_HOLD);
    // With credits outstanding, any response belongs to an already-flushed load.
    assign w_owned     = dram_rvalid & (r_discard_cnt == '0) & w_load & ~w_in_hold;

    assign w_offset  = mem_pipe_alu_result[c_OFF_W-1:0];
    assign w_shifted = dram_rdata >> {w_offset, 3'b000};

    always_comb begin
        w_aligned = w_shifted;
        case (mem_pipe_mem_size)
            2'd0:    w_aligned = mem_pipe_unsign ? XLEN'(w_shifted[7:0])
                                                 : XLEN'($signed(w_shifted[7:0]));
            2'd1:    w_aligned = mem_pipe_unsign ? XLEN'(w_shifted[15:0])
                                                 : XLEN'($signed(w_shifted[15:0]));
            2'd2:    w_aligned = mem_pipe_unsign ? XLEN'(w_shifted[31:0])
                                                 : XLEN'($signed(w_shifted[31:0]));
            default: w_aligned = w_shifted;
        endcase
    end

`ifdef MEM_MISALIGN_EXC_EN
    always_comb begin
        w_misal = 1'b0;
        if (mem_pipe_mem_read) begin
            case (mem_pipe_mem_size)
                2'd1:    w_misal = w_offset[0];
                2'd2:    w_misal = (w_offset[1:0] != 2'b00);
                2'd3:    w_misal = (w_offset != '0);
                default: w_misal = 1'b0;
            endcase
        end
    end
`else
    assign w_misal = 1'b0;
`endif

    assign w_misal_exc = w_misal & ~mem_pipe_exc_pending;
    assign w_done      = ~mem_pipe_mem_read | w_owned | w_in_hold | w_misal;
    assign w_xfer      = w_mem_valid & w_done & wb_pipe_ready;
    assign w_load_data = r_hold_valid ? r_hold_data : w_aligned;
    assign w_rd_data   = mem_pipe_mem_read ? w_load_data : mem_pipe_alu_result;

    // A load leaving MEM with its response still in flight earns one discard credit.
    assign w_inc = w_load & ~w_owned & ~w_in_hold & (wb_pipe_flush | (w_misal & wb_pipe_ready));
    assign w_dec = dram_rvalid & (r_discard_cnt != '0);

    always_comb begin
        w_cnt_next = r_discard_cnt;
        if (w_inc && !w_dec && (r_discard_cnt != c_CNT_MAX)) begin
            w_cnt_next = r_discard_cnt + c_CNT_ONE;
        end else if (w_dec && !w_inc) begin
            w_cnt_next = r_discard_cnt - c_CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_IDLE;
            r_hold_valid  <= 1'b0;
            r_discard_cnt <= '0;
            wb_pipe_valid <= 1'b0;
        end else begin
            r_discard_cnt <= w_cnt_next;
            if (wb_pipe_ready) begin
                wb_pipe_valid <= w_mem_valid & w_done;
            end
            case (r_state)
                c_IDLE: begin
                    if (w_mem_valid && mem_pipe_mem_read && !w_misal) begin
                        if (!w_owned) begin
                            r_state <= c_WAIT;
                        end else if (!wb_pipe_ready) begin
                            r_state      <= c_HOLD;
                            r_hold_valid <= 1'b1;
                            r_hold_data  <= w_aligned;
                        end
                    end
                end
                c_WAIT: begin
                    if (wb_pipe_flush) begin
                        r_state <= c_IDLE;
                    end else if (w_owned) begin
                        if (wb_pipe_ready) begin
                            r_state <= c_IDLE;
                        end else begin
                            r_state      <= c_HOLD;
                            r_hold_valid <= 1'b1;
                            r_hold_data  <= w_aligned;
                        end
                    end
                end
                c_HOLD: begin
                    if (wb_pipe_flush || wb_pipe_ready) begin
                        r_state      <= c_IDLE;
                        r_hold_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= c_IDLE;
                    r_hold_valid <= 1'b0;
                end
            endcase
        end
    end

    // Payload registers keep their contents through reset.
    always_ff @(posedge clk) begin
        if (!rst && w_xfer) begin
            wb_pipe_pc          <= mem_pipe_pc;
            wb_pipe_rd_write    <= mem_pipe_rd_write & ~w_misal;
            wb_pipe_rd_addr     <= mem_pipe_rd_addr;
            wb_pipe_rd_data     <= w_rd_data;
            wb_pipe_sideband    <= mem_pipe_sideband;
            wb_pipe_exc_pending <= mem_pipe_exc_pending | w_misal;
            wb_pipe_exc_code    <= w_misal_exc ? 4'd4 : mem_pipe_exc_code;
            wb_pipe_exc_tval    <= w_misal_exc ? mem_pipe_alu_result : mem_pipe_exc_tval;
        end
    end

    assign mem_pipe_ready    = ~w_mem_valid | (w_done & wb_pipe_ready);
    assign mem_pipe_flush    = wb_pipe_flush;
    assign mem_rd_write      = mem_pipe_rd_write & mem_pipe_valid;
    assign mem_rd_addr       = mem_pipe_rd_addr;
    assign mem_rd_wdata      = w_rd_data;
    assign mem_mem_read_wait = w_load & ~w_done;
    assign mem_lsu_stall     = (r_discard_cnt == c_CNT_MAX);

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_mem_stage_lsu: directed scoreboard bench for mem_stage_lsu          |
// | (XLEN=32 main instance, XLEN=64 alignment instance).                   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_mem_stage_lsu;

    logic        clk;
    logic        rst;
    logic        mem_pipe_valid, mem_pipe_ready, mem_pipe_flush;
    logic [31:0] mem_pipe_pc;
    logic        mem_pipe_mem_read;
    logic [1:0]  mem_pipe_mem_size;
    logic        mem_pipe_unsign, mem_pipe_rd_write;
    logic [4:0]  mem_pipe_rd_addr;
    logic [31:0] mem_pipe_alu_result;
    logic [63:0] mem_pipe_sideband;
    logic        mem_pipe_exc_pending;
    logic [3:0]  mem_pipe_exc_code;
    logic [31:0] mem_pipe_exc_tval;
    logic        wb_pipe_ready, wb_pipe_flush, wb_pipe_valid;
    logic [31:0] wb_pipe_pc;
    logic        wb_pipe_rd_write;
    logic [4:0]  wb_pipe_rd_addr;
    logic [31:0] wb_pipe_rd_data;
    logic [63:0] wb_pipe_sideband;
    logic        wb_pipe_exc_pending;
    logic [3:0]  wb_pipe_exc_code;
    logic [31:0] wb_pipe_exc_tval;
    logic        mem_rd_write;
    logic [4:0]  mem_rd_addr;
    logic [31:0] mem_rd_wdata;
    logic        mem_mem_read_wait, mem_lsu_stall;
    logic        dram_rvalid;
    logic [31:0] dram_rdata;

    logic        x_valid, x_ready, x_flush_o, x_read, x_uns, x_rvalid;
    logic [1:0]  x_size;
    logic [63:0] x_alu, x_rdata;
    logic        x_wb_valid, x_wb_rd_write, x_wb_exc, x_fwd_write, x_wait, x_stall;
    logic [63:0] x_wb_pc, x_wb_rd_data, x_wb_sb, x_wb_tval, x_fwd_data;
    logic [4:0]  x_wb_rd_addr, x_fwd_addr;
    logic [3:0]  x_wb_code;

    typedef struct {
        logic [31:0] pc;
        logic        rd_write;
        logic [4:0]  rd_addr;
        logic [31:0] rd_data;
        logic        exc;
        logic [3:0]  code;
        logic [31:0] tval;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    mem_stage_lsu #(.XLEN(32), .SB_W(64), .MAX_OUTSTANDING(4)) u_dut32 (
        .clk(clk), .rst(rst),
        .mem_pipe_valid(mem_pipe_valid), .mem_pipe_ready(mem_pipe_ready),
        .mem_pipe_flush(mem_pipe_flush), .mem_pipe_pc(mem_pipe_pc),
        .mem_pipe_mem_read(mem_pipe_mem_read), .mem_pipe_mem_size(mem_pipe_mem_size),
        .mem_pipe_unsign(mem_pipe_unsign), .mem_pipe_rd_write(mem_pipe_rd_write),
        .mem_pipe_rd_addr(mem_pipe_rd_addr), .mem_pipe_alu_result(mem_pipe_alu_result),
        .mem_pipe_sideband(mem_pipe_sideband), .mem_pipe_exc_pending(mem_pipe_exc_pending),
        .mem_pipe_exc_code(mem_pipe_exc_code), .mem_pipe_exc_tval(mem_pipe_exc_tval),
        .wb_pipe_ready(wb_pipe_ready), .wb_pipe_flush(wb_pipe_flush),
        .wb_pipe_valid(wb_pipe_valid), .wb_pipe_pc(wb_pipe_pc),
        .wb_pipe_rd_write(wb_pipe_rd_write), .wb_pipe_rd_addr(wb_pipe_rd_addr),
        .wb_pipe_rd_data(wb_pipe_rd_data), .wb_pipe_sideband(wb_pipe_sideband),
        .wb_pipe_exc_pending(wb_pipe_exc_pending), .wb_pipe_exc_code(wb_pipe_exc_code),
        .wb_pipe_exc_tval(wb_pipe_exc_tval), .mem_rd_write(mem_rd_write),
        .mem_rd_addr(mem_rd_addr), .mem_rd_wdata(mem_rd_wdata),
        .mem_mem_read_wait(mem_mem_read_wait), .mem_lsu_stall(mem_lsu_stall),
        .dram_rvalid(dram_rvalid), .dram_rdata(dram_rdata)
    );

    mem_stage_lsu #(.XLEN(64), .SB_W(64), .MAX_OUTSTANDING(4)) u_dut64 (
        .clk(clk), .rst(rst),
        .mem_pipe_valid(x_valid), .mem_pipe_ready(x_ready),
        .mem_pipe_flush(x_flush_o), .mem_pipe_pc(64'h0),
        .mem_pipe_mem_read(x_read), .mem_pipe_mem_size(x_size),
        .mem_pipe_unsign(x_uns), .mem_pipe_rd_write(1'b1),
        .mem_pipe_rd_addr(5'd3), .mem_pipe_alu_result(x_alu),
        .mem_pipe_sideband(64'h0), .mem_pipe_exc_pending(1'b0),
        .mem_pipe_exc_code(4'h0), .mem_pipe_exc_tval(64'h0),
        .wb_pipe_ready(1'b1), .wb_pipe_flush(1'b0),
        .wb_pipe_valid(x_wb_valid), .wb_pipe_pc(x_wb_pc),
        .wb_pipe_rd_write(x_wb_rd_write), .wb_pipe_rd_addr(x_wb_rd_addr),
        .wb_pipe_rd_data(x_wb_rd_data), .wb_pipe_sideband(x_wb_sb),
        .wb_pipe_exc_pending(x_wb_exc), .wb_pipe_exc_code(x_wb_code),
        .wb_pipe_exc_tval(x_wb_tval), .mem_rd_write(x_fwd_write),
        .mem_rd_addr(x_fwd_addr), .mem_rd_wdata(x_fwd_data),
        .mem_mem_read_wait(x_wait), .mem_lsu_stall(x_stall),
        .dram_rvalid(x_rvalid), .dram_rdata(x_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_pipe_valid       = 1'b0;
        mem_pipe_mem_read    = 1'b0;
        mem_pipe_exc_pending = 1'b0;
        wb_pipe_flush        = 1'b0;
        dram_rvalid          = 1'b0;
    endtask

    task automatic drive(input logic rd, input logic [1:0] size, input logic uns,
                         input logic [31:0] pc, input logic [31:0] alu, input logic [4:0] rda);
        mem_pipe_valid       = 1'b1;
        mem_pipe_mem_read    = rd;
        mem_pipe_mem_size    = size;
        mem_pipe_unsign      = uns;
        mem_pipe_pc          = pc;
        mem_pipe_alu_result  = alu;
        mem_pipe_rd_write    = 1'b1;
        mem_pipe_rd_addr     = rda;
        mem_pipe_sideband    = {32'hC0DE0000, pc};
        mem_pipe_exc_pending = 1'b0;
        mem_pipe_exc_code    = 4'h0;
        mem_pipe_exc_tval    = 32'h0;
    endtask

    task automatic push(input logic [31:0] pc, input logic rdw, input logic [4:0] rda,
                        input logic [31:0] data, input logic exc, input logic [3:0] code,
                        input logic [31:0] tval);
        exp_t e;
        e.pc = pc; e.rd_write = rdw; e.rd_addr = rda; e.rd_data = data;
        e.exc = exc; e.code = code; e.tval = tval;
        q.push_back(e);
    endtask

    // Every WB handshake must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && wb_pipe_valid && wb_pipe_ready) begin
            if (q.size() == 0) begin
                chk("wb_unexpected_entry", 64'(q.size()), 64'd1);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("wb_pc", 64'(wb_pipe_pc), 64'(e.pc));
                chk("wb_rd_write", 64'(wb_pipe_rd_write), 64'(e.rd_write));
                chk("wb_rd_addr", 64'(wb_pipe_rd_addr), 64'(e.rd_addr));
                if (e.rd_write) chk("wb_rd_data", 64'(wb_pipe_rd_data), 64'(e.rd_data));
                chk("wb_sideband", wb_pipe_sideband, {32'hC0DE0000, e.pc});
                chk("wb_exc_pending", 64'(wb_pipe_exc_pending), 64'(e.exc));
                chk("wb_exc_code", 64'(wb_pipe_exc_code), 64'(e.code));
                chk("wb_exc_tval", 64'(wb_pipe_exc_tval), 64'(e.tval));
            end
        end
    end

    initial begin
        rst = 1'b1;
        wb_pipe_ready = 1'b1;
        dram_rdata = 32'h0;
        mem_pipe_mem_size = 2'd0; mem_pipe_unsign = 1'b0; mem_pipe_pc = 32'h0;
        mem_pipe_alu_result = 32'h0; mem_pipe_rd_write = 1'b0; mem_pipe_rd_addr = 5'd0;
        mem_pipe_sideband = 64'h0; mem_pipe_exc_code = 4'h0; mem_pipe_exc_tval = 32'h0;
        idle();
        x_valid = 1'b0; x_read = 1'b0; x_size = 2'd0; x_uns = 1'b0;
        x_alu = 64'h0; x_rvalid = 1'b0; x_rdata = 64'h0;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_wb_valid", 64'(wb_pipe_valid), 64'd0);
        chk("rst_stall", 64'(mem_lsu_stall), 64'd0);
        chk("rst_ready", 64'(mem_pipe_ready), 64'd1);
        chk("rst_x_wb_valid", 64'(x_wb_valid), 64'd0);

        // Non-load with upstream exception fields passed through
        drive(1'b0, 2'd2, 1'b0, 32'h100, 32'h12345678, 5'd5);
        mem_pipe_exc_pending = 1'b1; mem_pipe_exc_code = 4'd2; mem_pipe_exc_tval = 32'hBAD;
        push(32'h100, 1'b1, 5'd5, 32'h12345678, 1'b1, 4'd2, 32'hBAD);
        #1;
        chk("alu_ready", 64'(mem_pipe_ready), 64'd1);
        chk("alu_fwd_write", 64'(mem_rd_write), 64'd1);
        chk("alu_fwd_data", 64'(mem_rd_wdata), 64'h12345678);
        tick(); idle();
        chk("alu_latency", 64'(wb_pipe_valid), 64'd1);
        tick();
        chk("alu_single", 64'(wb_pipe_valid), 64'd0);

        // LB at 0x103
        drive(1'b1, 2'd0, 1'b0, 32'h104, 32'h103, 5'd6);
        push(32'h104, 1'b1, 5'd6, 32'hFFFFFF80, 1'b0, 4'd0, 32'h0);
        #1;
        chk("lb_read_wait", 64'(mem_mem_read_wait), 64'd1);
        chk("lb_not_ready", 64'(mem_pipe_ready), 64'd0);
        tick();
        dram_rvalid = 1'b1; dram_rdata = 32'h80FF1234;
        #1;
        chk("lb_fwd_data", 64'(mem_rd_wdata), 64'hFFFFFF80);
        chk("lb_ready", 64'(mem_pipe_ready), 64'd1);
        chk("lb_wb_not_yet", 64'(wb_pipe_valid), 64'd0);
        tick(); idle();
        chk("lb_latency", 64'(wb_pipe_valid), 64'd1);
        tick();

        // LHU at 0x2 with WB back-pressure on the response cycle
        drive(1'b1, 2'd1, 1'b1, 32'h108, 32'h2, 5'd7);
        push(32'h108, 1'b1, 5'd7, 32'h0000BEEF, 1'b0, 4'd0, 32'h0);
        tick();
        dram_rvalid = 1'b1; dram_rdata = 32'hBEEF0000; wb_pipe_ready = 1'b0;
        #1;
        chk("lhu_bp_ready", 64'(mem_pipe_ready), 64'd0);
        tick();
        dram_rvalid = 1'b0; dram_rdata = 32'hDEADBEEF;
        #1;
        chk("lhu_hold_data", 64'(mem_rd_wdata), 64'h0000BEEF);
        chk("lhu_hold_no_wait", 64'(mem_mem_read_wait), 64'd0);
        tick();
        wb_pipe_ready = 1'b1;
        #1;
        chk("lhu_hold_release", 64'(mem_pipe_ready), 64'd1);
        tick(); idle();
        chk("lhu_wb_valid", 64'(wb_pipe_valid), 64'd1);
        tick();
        chk("lhu_once", 64'(wb_pipe_valid), 64'd0);

        // Load flushed in WAIT; its late response must be dropped
        drive(1'b1, 2'd2, 1'b0, 32'h10C, 32'h0, 5'd8);
        tick();
        wb_pipe_flush = 1'b1;
        #1;
        chk("flush_fwd", 64'(mem_pipe_flush), 64'd1);
        chk("flush_ready", 64'(mem_pipe_ready), 64'd1);
        tick(); idle();
        drive(1'b1, 2'd2, 1'b0, 32'h110, 32'h4, 5'd9);
        push(32'h110, 1'b1, 5'd9, 32'h22, 1'b0, 4'd0, 32'h0);
        tick();
        dram_rvalid = 1'b1; dram_rdata = 32'h11;
        #1;
        chk("stale_not_owned", 64'(mem_mem_read_wait), 64'd1);
        tick();
        dram_rdata = 32'h22;
        #1;
        chk("owned_data", 64'(mem_rd_wdata), 64'h22);
        tick(); idle();
        tick();

        // Saturate discard credits with four flushed loads
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'd2, 1'b0, 32'h200 + 32'(4 * i), 32'(4 * i), 5'd10);
            tick();
            wb_pipe_flush = 1'b1;
            tick(); idle();
        end
        #1;
        chk("stall_full", 64'(mem_lsu_stall), 64'd1);
        tick();
        chk("stall_held", 64'(mem_lsu_stall), 64'd1);
        dram_rvalid = 1'b1; dram_rdata = 32'h33;
        #1;
        chk("stall_same_cycle", 64'(mem_lsu_stall), 64'd1);
        tick();
        chk("stall_release", 64'(mem_lsu_stall), 64'd0);
        repeat (3) tick();
        drive(1'b1, 2'd0, 1'b1, 32'h220, 32'h0, 5'd11);
        dram_rvalid = 1'b1; dram_rdata = 32'h000000AB;
        push(32'h220, 1'b1, 5'd11, 32'hAB, 1'b0, 4'd0, 32'h0);
        #1;
        chk("drained_owned", 64'(mem_pipe_ready), 64'd1);
        tick(); idle();
        tick();

        // Flush coinciding with an owned response: no credit taken
        drive(1'b1, 2'd2, 1'b0, 32'h300, 32'h8, 5'd12);
        tick();
        wb_pipe_flush = 1'b1; dram_rvalid = 1'b1; dram_rdata = 32'h55;
        tick(); idle();
        drive(1'b1, 2'd1, 1'b0, 32'h304, 32'h0, 5'd13);
        dram_rvalid = 1'b1; dram_rdata = 32'h00008066;
        push(32'h304, 1'b1, 5'd13, 32'hFFFF8066, 1'b0, 4'd0, 32'h0);
        #1;
        chk("flush_owned_no_credit", 64'(mem_pipe_ready), 64'd1);
        tick(); idle();
        tick();

        // LW at 0x1002
        drive(1'b1, 2'd2, 1'b0, 32'h400, 32'h1002, 5'd14);
`ifdef MEM_MISALIGN_EXC_EN
        push(32'h400, 1'b0, 5'd14, 32'h0, 1'b1, 4'd4, 32'h1002);
        #1;
        chk("misal_immediate", 64'(mem_pipe_ready), 64'd1);
        tick(); idle();
        dram_rvalid = 1'b1; dram_rdata = 32'hEE;
        tick(); idle();
        drive(1'b1, 2'd0, 1'b1, 32'h404, 32'h0, 5'd15);
        dram_rvalid = 1'b1; dram_rdata = 32'h77;
        push(32'h404, 1'b1, 5'd15, 32'h77, 1'b0, 4'd0, 32'h0);
        #1;
        chk("misal_resp_dropped", 64'(mem_pipe_ready), 64'd1);
        tick(); idle();
`else
        push(32'h400, 1'b1, 5'd14, 32'h00001234, 1'b0, 4'd0, 32'h0);
        #1;
        chk("lw_off2_wait", 64'(mem_mem_read_wait), 64'd1);
        tick();
        dram_rvalid = 1'b1; dram_rdata = 32'h1234ABCD;
        #1;
        chk("lw_off2_data", 64'(mem_rd_wdata), 64'h00001234);
        tick(); idle();
`endif
        tick();

        // XLEN=64: LWU, LW and LD with same-cycle responses
        x_valid = 1'b1; x_read = 1'b1; x_size = 2'd2; x_uns = 1'b1; x_alu = 64'h1004;
        x_rvalid = 1'b1; x_rdata = 64'hFFFFFFFF_00000000;
        #1;
        chk("x_lwu_fwd", x_fwd_data, 64'h00000000_FFFFFFFF);
        tick();
        chk("x_lwu_wb", x_wb_rd_data, 64'h00000000_FFFFFFFF);
        chk("x_lwu_valid", 64'(x_wb_valid), 64'd1);
        x_uns = 1'b0;
        tick();
        chk("x_lw_wb", x_wb_rd_data, 64'hFFFFFFFF_FFFFFFFF);
        x_size = 2'd3; x_alu = 64'h1000; x_rdata = 64'h01234567_89ABCDEF;
        tick();
        chk("x_ld_wb", x_wb_rd_data, 64'h01234567_89ABCDEF);
        x_valid = 1'b0; x_read = 1'b0; x_rvalid = 1'b0;

        repeat (3) tick();
        chk("sb_empty", 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
